// File: rtl/instruction_decode_stage_pkg.sv
// Shared types for the decode stage: ALU operation codes, the control bundle
// handed to execute, RV32I major opcodes and the funct3-to-ALU mapping.
package instruction_decode_stage_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] instruction_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       is_branch;
    logic       is_jump;
    logic [2:0] funct3;
  } control_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Base ALU op for a funct3 value; SUB/SRA selection is layered on by the caller.
  function automatic alu_op_t funct3_alu(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decode_stage_register_file.sv
// 32x32 architectural register file: two combinational read ports with
// write-through bypass, one synchronous write port, x0 hardwired to zero.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        write_enable,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data
);

  logic [31:0] regs [32];

  // Synchronous clear on reset, otherwise commit write-back (never to x0).
  // NOTE: this array is reset explicitly because software may read any register
  // before writing it; the loop is why it maps to flops, not an SRAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_enable && write_addr != 5'd0) begin
      regs[write_addr] <= write_data;
    end
  end

  // Read port 1: x0 is zero, a same-cycle write to the register wins.
  always_comb begin
    if (rs1_addr == 5'd0)                             rs1_data = '0;
    else if (write_enable && write_addr == rs1_addr)  rs1_data = write_data;
    else                                              rs1_data = regs[rs1_addr];
  end

  // Read port 2: same bypass rule as port 1.
  always_comb begin
    if (rs2_addr == 5'd0)                             rs2_data = '0;
    else if (write_enable && write_addr == rs2_addr)  rs2_data = write_data;
    else                                              rs2_data = regs[rs2_addr];
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: field extraction, immediate generation, control decode
// and register read, all registered into the ID/EX boundary.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_in,
  input  instruction_t instruction,
  input  logic         flush,
  input  logic         wb_write_enable,
  input  logic [4:0]   wb_rd,
  input  logic [31:0]  wb_data,
  output logic [31:0]  pc_out,
  output logic [31:0]  rs1_data,
  output logic [31:0]  rs2_data,
  output logic [4:0]   rs1,
  output logic [4:0]   rs2,
  output logic [4:0]   rd,
  output logic [31:0]  imm,
  output control_t     control,
  output logic         valid,
  output logic         illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        alt;
  logic [31:0] rs1_data_d, rs2_data_d, imm_d;
  control_t    ctrl_d;
  logic        illegal_d;

  assign opcode = instruction[6:0];
  assign rd_d   = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1_d  = instruction[19:15];
  assign rs2_d  = instruction[24:20];
  assign alt    = instruction[30];   // funct7[5]: SUB / SRA selector

  register_file u_register_file (
    .clk          (clk),
    .rst          (rst),
    .rs1_addr     (rs1_d),
    .rs2_addr     (rs2_d),
    .rs1_data     (rs1_data_d),
    .rs2_data     (rs2_data_d),
    .write_enable (wb_write_enable),
    .write_addr   (wb_rd),
    .write_data   (wb_data)
  );

  // Immediate generation by instruction format; R-type and unknown give zero.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    imm_d = '0;
    case (opcode)
      OP_JALR, OP_LOAD, OP_IMM:
        imm_d = {{20{instruction[31]}}, instruction[31:20]};
      OP_STORE:
        imm_d = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BRANCH:
        imm_d = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_d = {instruction[31:12], 12'b0};
      OP_JAL:
        imm_d = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
      default: ;
    endcase
  end

  // Control decode; unknown opcodes flag illegal and carry no control bits.
  always_comb begin
    ctrl_d        = '0;
    ctrl_d.funct3 = funct3;
    illegal_d     = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl_d.alu_op      = ALU_PASS_B;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.reg_write   = 1'b1;
      end
      OP_AUIPC: begin
        ctrl_d.alu_src_pc  = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.reg_write   = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.is_jump     = 1'b1;
        ctrl_d.alu_src_pc  = 1'b1;
        ctrl_d.reg_write   = 1'b1;
      end
      OP_JALR: begin
        ctrl_d.is_jump     = 1'b1;
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.reg_write   = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_d.is_branch   = 1'b1;
        ctrl_d.alu_op      = ALU_SUB;
      end
      OP_LOAD: begin
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.mem_read    = 1'b1;
        ctrl_d.mem_to_reg  = 1'b1;
        ctrl_d.reg_write   = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.mem_write   = 1'b1;
      end
      OP_IMM: begin
        ctrl_d.alu_op      = (funct3 == 3'b101 && alt) ? ALU_SRA : funct3_alu(funct3);
        ctrl_d.alu_src_imm = 1'b1;
        ctrl_d.reg_write   = 1'b1;
      end
      OP_OP: begin
        ctrl_d.alu_op = funct3_alu(funct3);
        if (alt && funct3 == 3'b000) ctrl_d.alu_op = ALU_SUB;
        if (alt && funct3 == 3'b101) ctrl_d.alu_op = ALU_SRA;
        ctrl_d.reg_write = 1'b1;
      end
      default: begin
        ctrl_d    = '0;
        illegal_d = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally dropped; don't advertise them downstream.
    if (rd_d == 5'd0) ctrl_d.reg_write = 1'b0;
  end

  // ID/EX boundary: reset and flush both load an all-zero bubble, reset first.
  // NOTE: non-blocking assignments here so every flop samples the pre-edge
  // values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc_out   <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      rs1      <= '0;
      rs2      <= '0;
      rd       <= '0;
      imm      <= '0;
      control  <= '0;
      valid    <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      pc_out   <= pc_in;
      rs1_data <= rs1_data_d;
      rs2_data <= rs2_data_d;
      rs1      <= rs1_d;
      rs2      <= rs2_d;
      rd       <= rd_d;
      imm      <= imm_d;
      control  <= ctrl_d;
      valid    <= !illegal_d;
      illegal  <= illegal_d;
    end
  end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Second pipeline stage: takes the PC and the decompressed 32-bit RV32I instruction from the fetch stage, reads the architectural register file, and generates the sign-extended immediate and control bundle. Results are registered into the ID/EX boundary for the execute stage. The stage also owns the 32×32 register file and its write-back port.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pc_in  in  32  PC of the instruction being decoded
- instruction  in  32 (instruction_t)  decompressed RV32I instruction word
- flush  in  1  taken branch; the next ID/EX contents are a bubble
- wb_write_enable  in  1  register file write strobe
- wb_rd  in  5  write-back destination
- wb_data  in  32  write-back data
- pc_out  out  32  registered pc_in
- rs1_data, rs2_data  out  32 each  operand values
- rs1, rs2, rd  out  5 each  register indices
- imm  out  32  sign-extended immediate
- control  out  control_t  alu_op, alu_src_imm, alu_src_pc, mem_read, mem_write, reg_write, mem_to_reg, is_branch, is_jump, funct3
- valid  out  1  ID/EX slot holds a real instruction
- illegal  out  1  registered illegal-opcode flag

## Operation
- Field extraction:
  - opcode = instruction[6:0]
  - rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], funct7 = [31:25]
- Immediate generation:
  - I-type: [31:20]
  - S-type: {[31:25],[11:7]}
  - B-type: {[31],[7],[30:25],[11:8],0}
  - U-type: {[31:12],12'b0}
  - J-type: {[31],[19:12],[20],[30:21],0}
  - All immediates are sign-extended from bit 31. R-type produces imm = 0.
- Opcode decode:
  - LUI: alu_op PASS_B, alu_src_imm, reg_write.
  - AUIPC: ADD, alu_src_pc, alu_src_imm, reg_write.
  - JAL: is_jump, alu_src_pc, reg_write.
  - JALR: is_jump, alu_src_imm, reg_write.
  - BRANCH: is_branch, SUB.
  - LOAD: ADD, alu_src_imm, mem_read, mem_to_reg, reg_write.
  - STORE: ADD, alu_src_imm, mem_write.
  - OP-IMM: funct3 selects the ALU op; funct3=101 with funct7[5]=1 selects SRA, otherwise SRL; funct3=000 is always ADD.
  - OP: funct3 selects the ALU op; funct7[5] selects SUB over ADD and SRA over SRL.
  - Any other opcode: illegal=1, valid=0, all control bits 0.
  - rd=0 clears reg_write.
- Register file:
  - x0 reads 0 and ignores writes.
  - Writes are synchronous on posedge when wb_write_enable=1.
  - Reads are combinational with write-through bypass: when wb_write_enable=1, wb_rd≠0, and wb_rd matches rs1 or rs2, that read returns wb_data in the same cycle.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset (rst=1 at the edge):
  - All outputs clear to 0, including valid and illegal.
  - All 32 registers clear to 0.
  - Write-back is ignored during reset.
- Flush=1 at an edge:
  - Registers a bubble: valid=0, control all 0, illegal=0. Other fields are don't-care but are driven to 0.
  - A register file write in the same cycle still commits.
- Reset has priority over flush; flush has priority over normal decode.
- The stage has no stall input: a new instruction is accepted every cycle.
- Simultaneous write and read of the same register returns the new value (bypass). The write commits at the same edge.

## Structure
- common_pkg additions:
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B
  - control_t packed struct
  - opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP
- Sub-module register_file: two combinational read ports with bypass, one synchronous write port, synchronous reset.
- Immediate generation and control decode stay combinational inside the stage, ahead of the ID/EX flops.

## Test plan
- After reset, with instruction=0x00500093 (addi x1,x0,5), pc_in=0x10: the next cycle gives rd=1, rs1=0, imm=5, alu_op ADD, alu_src_imm=1, reg_write=1, valid=1, pc_out=0x10.
- Write x1=0xDEADBEEF in the same cycle as decoding 0x00108133 (add x2,x1,x1): rs1_data = rs2_data = 0xDEADBEEF. On the following cycle, reading x1 without a write still gives 0xDEADBEEF.
- Write x0=0x12345678, then decode add using x0: rs1_data = 0.
- Decode 0xFE000EE3 (beq x0,x0,-4): imm=0xFFFFFFFC, is_branch=1, alu_op SUB, reg_write=0. Decode 0x4020D193 (srai x3,x1,2): alu_op SRA, imm[4:0]=2.
- Decode 0x00000000: illegal=1, valid=0, control all 0. Assert flush while decoding a valid addi: valid=0, reg_write=0 the next cycle.
- Assert rst mid-stream after registers are written: outputs are 0 the next cycle, and subsequent reads of x1–x31 return 0.
